bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 32 +++
 rtl/bus_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the requesting masters (plus crossbar done) and the arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 16
) ();
  localparam int IDW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] request;
  logic                   done;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    output request,
    output done,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  request,
    input  done,
    output grant,
    output grant_id,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Single-owner bus arbiter: round-robin or fixed-priority selection, registered one-hot grant,
// mandatory one-cycle bubble between grants and an optional hold timeout.
module bus_arbiter #(
  parameter int NUM_MASTERS = 16,
  parameter int MODE        = 0,
  parameter int TIMEOUT     = 0
) (
  input logic          clk,
  input logic          rst_n,
  bus_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_MASTERS - 1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic          win_found;
  logic [IW-1:0] win_idx;
  int            scan_idx;
  logic          grantee_req;
  logic          timeout_hit;
  logic          release_now;

  // Round-robin scans upward from ptr with wrap; fixed priority always scans from index 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scan_idx = (MODE == 1) ? k : (int'(ptr) + k) % NUM_MASTERS;
      if (!win_found && bus.request[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan_idx);
      end
    end
  end

  assign grantee_req = |(bus.request & bus.grant);
  assign timeout_hit = (TIMEOUT != 0) && (state == OWNED) && (cnt == CNT_LIMIT);
  assign release_now = bus.done || !grantee_req || timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      bus.grant       <= '0;
      bus.grant_id    <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state        <= OWNED;
            bus.grant    <= NUM_MASTERS'(1) << win_idx;
            bus.grant_id <= win_idx;
            bus.busy     <= 1'b1;
            cnt          <= '0;
            if (MODE == 0) begin
              ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            end
          end
        end
        OWNED: begin
          // done takes precedence, so a timeout coinciding with done is a clean release.
          if (release_now) begin
            state           <= IDLE;
            bus.grant       <= '0;
            bus.grant_id    <= '0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= timeout_hit && !bus.done;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
